branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_pkg.sv | 35 +++
 rtl/bp_sat_counter.sv | 32 +++
 rtl/branch_predictor.sv | 150 +++++++++++++++
 tb/tb_branch_predictor.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit direction counter encodings,
// the counter step function and the PC field positions used for index/tag extraction.
package branch_predictor_pkg;

  // 2-bit direction counter; MSB set means "predict taken".
  typedef enum logic [1:0] {
    CtrStrongNt = 2'b00,
    CtrWeakNt   = 2'b01,
    CtrWeakT    = 2'b10,
    CtrStrongT  = 2'b11
  } ctr2_e;

  // Instructions are word aligned, so the index starts above the byte offset.
  localparam int unsigned PcIdxLsb  = 2;
  localparam logic [31:0] InstBytes = 32'd4;

  // Saturating step of a direction counter towards the resolved outcome.
  function automatic ctr2_e ctr2_step(input ctr2_e ctr, input logic taken);
    ctr2_e nxt;
    nxt = ctr;
    case (ctr)
      CtrStrongNt: nxt = taken ? CtrWeakNt  : CtrStrongNt;
      CtrWeakNt:   nxt = taken ? CtrWeakT   : CtrStrongNt;
      CtrWeakT:    nxt = taken ? CtrStrongT : CtrWeakNt;
      CtrStrongT:  nxt = taken ? CtrStrongT : CtrWeakT;
      default:     nxt = CtrWeakNt;
    endcase
    return nxt;
  endfunction

  function automatic logic ctr2_taken(input ctr2_e ctr);
    return (ctr == CtrWeakT) || (ctr == CtrStrongT);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Width-bit event counter that sticks at all-ones instead of wrapping.
module bp_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  // Next count: step by one unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + Width'(1'b1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: tagged BTB entries with 2-bit direction counters,
// bimodal (GHR_W=0) or gshare (GHR_W>0) indexing, and saturating update/miss statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned GHR_W   = 0,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned IDX    = $clog2(ENTRIES),
  localparam int unsigned GW     = (GHR_W > 0) ? GHR_W : 1
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic [31:0]      LOOKUP_PC,
  output logic             PRED_TAKEN,
  output logic [31:0]      PRED_TARGET,
  output logic [GW-1:0]    PRED_GHR,
  input  logic             UPD_VALID,
  input  logic [31:0]      UPD_PC,
  input  logic             UPD_TAKEN,
  input  logic [31:0]      UPD_TARGET,
  input  logic [GW-1:0]    UPD_GHR,
  input  logic             UPD_MISPRED,
  input  logic             INVALIDATE,
  output logic [CNT_W-1:0] UPD_COUNT,
  output logic [CNT_W-1:0] MISS_COUNT
);

  localparam int unsigned TagLsb = IDX + PcIdxLsb;

  // Table state; tags and targets carry no reset since valid gates their use.
  logic [ENTRIES-1:0] valid_q, valid_d;
  ctr2_e              ctr_q [ENTRIES];
  ctr2_e              ctr_d [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [31:0]        tgt_d [ENTRIES];
  logic [GW-1:0]      ghr_q, ghr_d;

  logic [IDX-1:0]     lk_hist, up_hist;
  logic [IDX-1:0]     lk_idx, up_idx;
  logic [TAG_W-1:0]   lk_tag, up_tag;
  logic               lk_hit, up_hit;
  logic               unused_upd;

  // History folded into the index; stays zero for bimodal so the XOR drops out.
  always_comb begin
    lk_hist = '0;
    up_hist = '0;
    if (GHR_W > 0) begin
      lk_hist[GW-1:0] = ghr_q;
      up_hist[GW-1:0] = UPD_GHR;
    end
  end

  assign lk_idx = LOOKUP_PC[IDX+1:PcIdxLsb] ^ lk_hist;
  assign up_idx = UPD_PC[IDX+1:PcIdxLsb] ^ up_hist;
  assign lk_tag = LOOKUP_PC[TAG_W+TagLsb-1:TagLsb];
  assign up_tag = UPD_PC[TAG_W+TagLsb-1:TagLsb];

  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Byte offset and bits above the tag never select an entry.
  assign unused_upd = ^{UPD_PC[1:0], UPD_PC >> (TAG_W + TagLsb), UPD_GHR};

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  always_comb begin
    PRED_TAKEN  = lk_hit && ctr2_taken(ctr_q[lk_idx]);
    PRED_TARGET = PRED_TAKEN ? tgt_q[lk_idx] : (LOOKUP_PC + InstBytes);
    PRED_GHR    = ghr_q;
  end

  // Table and history next state; invalidate wins over a coincident update.
  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ghr_d   = ghr_q;
    if (INVALIDATE) begin
      valid_d = '0;
      ghr_d   = '0;
    end else if (UPD_VALID) begin
      if (up_hit) begin
        ctr_d[up_idx] = ctr2_step(ctr_q[up_idx], UPD_TAKEN);
        if (UPD_TAKEN) begin
          tgt_d[up_idx] = UPD_TARGET;
        end
      end else if (UPD_TAKEN) begin
        // Taken miss replaces whatever lived at this index.
        valid_d[up_idx] = 1'b1;
        tag_d[up_idx]   = up_tag;
        tgt_d[up_idx]   = UPD_TARGET;
        ctr_d[up_idx]   = CtrWeakT;
      end
      if (GHR_W > 0) begin
        ghr_d    = ghr_q << 1;
        ghr_d[0] = UPD_TAKEN;
      end
    end
  end

  // Valid bits, direction counters and history; reset gives a cold table.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      valid_q <= '0;
      ghr_q   <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CtrWeakNt;
      end
    end else begin
      valid_q <= valid_d;
      ghr_q   <= ghr_d;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= ctr_d[i];
      end
    end
  end

  // Tag and target payload storage.
  always_ff @(posedge CLOCK) begin
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      tag_q[i] <= tag_d[i];
      tgt_q[i] <= tgt_d[i];
    end
  end

  // Every accepted update is counted, including one dropped by a coincident invalidate.
  bp_sat_counter #(
    .Width(CNT_W)
  ) u_upd_count (
    .clk_i  (CLOCK),
    .rst_ni (RESET_N),
    .inc_i  (UPD_VALID),
    .count_o(UPD_COUNT)
  );

  bp_sat_counter #(
    .Width(CNT_W)
  ) u_miss_count (
    .clk_i  (CLOCK),
    .rst_ni (RESET_N),
    .inc_i  (UPD_VALID && UPD_MISPRED),
    .count_o(MISS_COUNT)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: two predictor configurations (bimodal/16-bit stats and
// gshare-2/4-bit stats) share one stimulus stream and are checked every cycle
// against a behavioural table model, plus literal expectations for known scenarios.
module tb_branch_predictor;

  localparam int unsigned NE = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lookup_pc, upd_pc, upd_target;
  logic        upd_valid, upd_taken, upd_mispred, invalidate;
  logic        upd_ghr_a;
  logic [1:0]  upd_ghr_b;

  logic        pa_taken, pb_taken;
  logic [31:0] pa_target, pb_target;
  logic        pa_ghr;
  logic [1:0]  pb_ghr;
  logic [15:0] pa_upd, pa_miss;
  logic [3:0]  pb_upd, pb_miss;

  int unsigned total = 0;
  int unsigned bad   = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16), .TAG_W(8), .GHR_W(0), .CNT_W(16)) dut_a (
    .CLOCK(clk), .RESET_N(rst_n), .LOOKUP_PC(lookup_pc),
    .PRED_TAKEN(pa_taken), .PRED_TARGET(pa_target), .PRED_GHR(pa_ghr),
    .UPD_VALID(upd_valid), .UPD_PC(upd_pc), .UPD_TAKEN(upd_taken),
    .UPD_TARGET(upd_target), .UPD_GHR(upd_ghr_a), .UPD_MISPRED(upd_mispred),
    .INVALIDATE(invalidate), .UPD_COUNT(pa_upd), .MISS_COUNT(pa_miss)
  );

  branch_predictor #(.ENTRIES(16), .TAG_W(8), .GHR_W(2), .CNT_W(4)) dut_b (
    .CLOCK(clk), .RESET_N(rst_n), .LOOKUP_PC(lookup_pc),
    .PRED_TAKEN(pb_taken), .PRED_TARGET(pb_target), .PRED_GHR(pb_ghr),
    .UPD_VALID(upd_valid), .UPD_PC(upd_pc), .UPD_TAKEN(upd_taken),
    .UPD_TARGET(upd_target), .UPD_GHR(upd_ghr_b), .UPD_MISPRED(upd_mispred),
    .INVALIDATE(invalidate), .UPD_COUNT(pb_upd), .MISS_COUNT(pb_miss)
  );

  // ---------------- behavioural model (index 0 = dut_a, 1 = dut_b) ----------------
  bit          m_valid [2][NE];
  int unsigned m_tag   [2][NE];
  int unsigned m_tgt   [2][NE];
  int unsigned m_ctr   [2][NE];
  int unsigned m_ghr   [2];
  int unsigned m_upd   [2];
  int unsigned m_miss  [2];

  function automatic int unsigned gbits(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic int unsigned cmax(input int d);
    return (d == 0) ? 65535 : 15;
  endfunction

  function automatic int unsigned m_index(input logic [31:0] pc, input int unsigned g);
    return ((pc >> 2) ^ g) % NE;
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return (pc >> 6) & 32'hFF;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int e = 0; e < NE; e++) begin
        m_valid[d][e] = 1'b0;
        m_ctr[d][e]   = 1;
      end
      m_ghr[d]  = 0;
      m_upd[d]  = 0;
      m_miss[d] = 0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int unsigned g;
      int unsigned i;
      bit          hit;
      g = (d == 0) ? 0 : upd_ghr_b;
      if (upd_valid) begin
        if (m_upd[d] < cmax(d)) m_upd[d]++;
        if (upd_mispred && (m_miss[d] < cmax(d))) m_miss[d]++;
      end
      if (invalidate) begin
        for (int e = 0; e < NE; e++) m_valid[d][e] = 1'b0;
        m_ghr[d] = 0;
      end else if (upd_valid) begin
        i   = m_index(upd_pc, g);
        hit = m_valid[d][i] && (m_tag[d][i] == m_tagof(upd_pc));
        if (hit) begin
          if (upd_taken) begin
            m_ctr[d][i] = (m_ctr[d][i] == 3) ? 3 : m_ctr[d][i] + 1;
            m_tgt[d][i] = upd_target;
          end else begin
            m_ctr[d][i] = (m_ctr[d][i] == 0) ? 0 : m_ctr[d][i] - 1;
          end
        end else if (upd_taken) begin
          m_valid[d][i] = 1'b1;
          m_tag[d][i]   = m_tagof(upd_pc);
          m_tgt[d][i]   = upd_target;
          m_ctr[d][i]   = 2;
        end
        if (gbits(d) > 0) m_ghr[d] = ((m_ghr[d] << 1) | upd_taken) % (1 << gbits(d));
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int d, input logic act_tk, input logic [31:0] act_tg,
                     input logic [31:0] act_ghr, input logic [31:0] act_upd,
                     input logic [31:0] act_miss);
    int unsigned li;
    bit          hit, tk;
    logic [31:0] tg;
    li  = m_index(lookup_pc, m_ghr[d]);
    hit = m_valid[d][li] && (m_tag[d][li] == m_tagof(lookup_pc));
    tk  = hit && (m_ctr[d][li] >= 2);
    tg  = tk ? m_tgt[d][li] : lookup_pc + 32'd4;
    check((d == 0) ? "a_pred_taken"  : "b_pred_taken",  {31'd0, act_tk}, {31'd0, tk});
    check((d == 0) ? "a_pred_target" : "b_pred_target", act_tg, tg);
    check((d == 0) ? "a_pred_ghr"    : "b_pred_ghr",    act_ghr, m_ghr[d]);
    check((d == 0) ? "a_upd_count"   : "b_upd_count",   act_upd, m_upd[d]);
    check((d == 0) ? "a_miss_count"  : "b_miss_count",  act_miss, m_miss[d]);
  endtask

  // Per-cycle comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, pa_taken, pa_target, {31'd0, pa_ghr}, {16'd0, pa_upd}, {16'd0, pa_miss});
      cmp(1, pb_taken, pb_target, {30'd0, pb_ghr}, {28'd0, pb_upd}, {28'd0, pb_miss});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                     input logic mis);
    upd_valid   = 1'b1;
    upd_pc      = pc;
    upd_taken   = tk;
    upd_target  = tg;
    upd_mispred = mis;
  endtask

  task automatic idle();
    upd_valid   = 1'b0;
    upd_mispred = 1'b0;
    invalidate  = 1'b0;
  endtask

  initial begin
    // Reset with a live update strobe that must be ignored.
    rst_n = 1'b0; lookup_pc = 32'h40; invalidate = 1'b0;
    upd_ghr_a = 1'b0; upd_ghr_b = 2'd0;
    upd(32'h40, 1'b1, 32'h100, 1'b1);
    model_reset();
    repeat (2) tick();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_taken", {31'd0, pa_taken}, 32'd0);
    check("rst_target", pa_target, 32'h44);
    check("rst_upd_count", {16'd0, pa_upd}, 32'd0);
    check("rst_miss_count", {16'd0, pa_miss}, 32'd0);
    check("rst_ghr_b", {30'd0, pb_ghr}, 32'd0);
    idle();
    rst_n = 1'b1;
    tick();

    // Taken allocation, then two not-taken updates.
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    @(negedge clk); check("cold_lookup_nt", {31'd0, pa_taken}, 32'd0);
    tick(); idle();
    @(negedge clk);
    check("alloc_taken", {31'd0, pa_taken}, 32'd1);
    check("alloc_target", pa_target, 32'h100);
    upd(32'h40, 1'b0, 32'h0, 1'b1);
    tick(); tick(); idle();
    @(negedge clk);
    check("two_nt_taken", {31'd0, pa_taken}, 32'd0);
    check("two_nt_target", pa_target, 32'h44);
    check("upd_count_3", {16'd0, pa_upd}, 32'd3);
    check("miss_count_2", {16'd0, pa_miss}, 32'd2);

    // Saturation at strong-taken.
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    repeat (4) tick();
    idle();
    @(negedge clk); check("four_t_taken", {31'd0, pa_taken}, 32'd1);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    tick(); idle();
    @(negedge clk); check("one_nt_still_taken", {31'd0, pa_taken}, 32'd1);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    tick(); idle();
    @(negedge clk); check("second_nt_not_taken", {31'd0, pa_taken}, 32'd0);

    // Alias at same index, different tag replaces the entry.
    upd(32'h440, 1'b1, 32'h200, 1'b0);
    tick(); idle();
    @(negedge clk);
    check("alias_old_miss", {31'd0, pa_taken}, 32'd0);
    check("alias_old_target", pa_target, 32'h44);
    tick(); lookup_pc = 32'h440;
    @(negedge clk);
    check("alias_new_hit", {31'd0, pa_taken}, 32'd1);
    check("alias_new_target", pa_target, 32'h200);

    // Sequential PC wraps modulo 2^32.
    tick(); lookup_pc = 32'hFFFF_FFFC;
    @(negedge clk); check("pc_wrap_target", pa_target, 32'h0);

    // Same-cycle lookup/update on a cold table, then invalidate priority.
    tick(); invalidate = 1'b1;
    tick(); invalidate = 1'b0;
    lookup_pc = 32'h80;
    upd(32'h80, 1'b1, 32'h300, 1'b0);
    @(negedge clk);
    check("same_cycle_old", {31'd0, pa_taken}, 32'd0);
    check("same_cycle_old_tgt", pa_target, 32'h84);
    tick(); idle();
    @(negedge clk);
    check("same_cycle_next", {31'd0, pa_taken}, 32'd1);
    check("same_cycle_next_tgt", pa_target, 32'h300);
    upd(32'h440, 1'b1, 32'h500, 1'b0);
    invalidate = 1'b1;
    tick(); idle();
    @(negedge clk); check("inval_clears_80", {31'd0, pa_taken}, 32'd0);
    tick(); lookup_pc = 32'h440;
    @(negedge clk); check("inval_beats_update", {31'd0, pa_taken}, 32'd0);

    // Asynchronous reset mid-cycle, released mid-stream.
    tick();
    upd(32'h80, 1'b1, 32'h300, 1'b0); lookup_pc = 32'h80;
    tick(); idle();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_taken", {31'd0, pa_taken}, 32'd0);
    check("async_rst_count", {16'd0, pa_upd}, 32'd0);
    tick(); rst_n = 1'b1;
    @(negedge clk); check("post_rst_cold", {31'd0, pa_taken}, 32'd0);

    // Statistic saturation on the 4-bit configuration.
    tick();
    upd(32'h40, 1'b0, 32'h0, 1'b1);
    repeat (20) tick();
    idle();
    @(negedge clk);
    check("b_upd_sat", {28'd0, pb_upd}, 32'd15);
    check("b_miss_sat", {28'd0, pb_miss}, 32'd15);
    check("a_upd_20", {16'd0, pa_upd}, 32'd20);
    check("a_miss_20", {16'd0, pa_miss}, 32'd20);

    // Randomised traffic over a small PC pool so entries collide and hit.
    for (int n = 0; n < 3000; n++) begin
      tick();
      lookup_pc   = $urandom_range(0, 255) << 2;
      upd_pc      = ($urandom_range(0, 3) == 0) ? lookup_pc : ($urandom_range(0, 255) << 2);
      upd_valid   = ($urandom_range(0, 1) == 1);
      upd_taken   = ($urandom_range(0, 9) < 6);
      upd_target  = $urandom;
      upd_mispred = ($urandom_range(0, 1) == 1);
      invalidate  = ($urandom_range(0, 49) == 0);
      upd_ghr_b   = ($urandom_range(0, 1) == 1) ? 2'(m_ghr[1]) : 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
    end
    tick(); idle();
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
